// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the timer's single-ended PWM into a complementary
// high-side / low-side drive pair with a programmable dead window between
// the two sides, so both outputs are never high together.
// Optional fault latch is compiled in when PWM_DEADTIME_FAULT_EN is defined.
//
// Control semantics: go is a level enable (low forces IDLE on the next edge,
// overriding everything else); relatch is a one-cycle pulse, sampled only
// while go=1 and not IDLE, that reloads the dead-time setting for the next
// window without disturbing the window in progress.
module pwm_deadtime #(
    parameter int DEAD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    input  logic                 go,
    input  logic [DEAD_BITS-1:0] dead_cnt,
    input  logic                 relatch,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic                 fault,
    output logic                 fault_latched,
`endif
    output logic                 out_hi,
    output logic                 out_lo,
    output logic                 dead_active,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DEAD_TO_HI = 3'd1,
        ST_HI_ON      = 3'd2,
        ST_DEAD_TO_LO = 3'd3,
        ST_LO_ON      = 3'd4
`ifdef PWM_DEADTIME_FAULT_EN
        , ST_FAULT    = 3'd5
`endif
    } state_t;

    localparam logic [DEAD_BITS-1:0] CNT_ONE = {{(DEAD_BITS-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [DEAD_BITS-1:0] dead_l_q, dead_l_d;
    logic [DEAD_BITS-1:0] cnt_q, cnt_d;
    logic                 pwm_r_q;
    logic                 out_hi_q, out_lo_q, dead_active_q;
`ifdef PWM_DEADTIME_FAULT_EN
    logic                 fault_latched_q;
`endif

    // Next-state logic: go=0 wins, then fault, then the normal drive sequence.
    always_comb begin
        state_d  = state_q;
        dead_l_d = dead_l_q;
        cnt_d    = cnt_q;
        if (!go) begin
            state_d = ST_IDLE;
        end
`ifdef PWM_DEADTIME_FAULT_EN
        else if (state_q == ST_FAULT) begin
            state_d = ST_FAULT;
        end
        else if (fault && (state_q != ST_IDLE)) begin
            state_d = ST_FAULT;
        end
`endif
        else begin
            if (relatch && (state_q != ST_IDLE)) begin
                dead_l_d = dead_cnt;
            end
            case (state_q)
                ST_IDLE: begin
                    // Startup always passes through a full dead window.
                    dead_l_d = dead_cnt;
                    cnt_d    = dead_cnt;
                    state_d  = pwm_r_q ? ST_DEAD_TO_HI : ST_DEAD_TO_LO;
                end
                ST_LO_ON: begin
                    if (pwm_r_q) begin
                        state_d = ST_DEAD_TO_HI;
                        cnt_d   = dead_l_q;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_r_q) begin
                        state_d = ST_DEAD_TO_LO;
                        cnt_d   = dead_l_q;
                    end
                end
                ST_DEAD_TO_HI: begin
                    // Request withdrawn: the high side never turned on, so the
                    // low side may come straight back.
                    if (!pwm_r_q) begin
                        state_d = ST_LO_ON;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HI_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DEAD_TO_LO: begin
                    if (pwm_r_q) begin
                        state_d = ST_HI_ON;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LO_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dead_l_q      <= '0;
            cnt_q         <= '0;
            pwm_r_q       <= 1'b0;
            out_hi_q      <= 1'b0;
            out_lo_q      <= 1'b0;
            dead_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dead_l_q      <= dead_l_d;
            cnt_q         <= cnt_d;
            pwm_r_q       <= pwm_in;
            out_hi_q      <= (state_d == ST_HI_ON);
            out_lo_q      <= (state_d == ST_LO_ON);
            dead_active_q <= (state_d == ST_DEAD_TO_HI) || (state_d == ST_DEAD_TO_LO);
        end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    // Fault indicator mirrors residence in the FAULT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched_q <= 1'b0;
        end else begin
            fault_latched_q <= (state_d == ST_FAULT);
        end
    end

    assign fault_latched = fault_latched_q;
`endif

    assign out_hi      = out_hi_q;
    assign out_lo      = out_lo_q;
    assign dead_active = dead_active_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Testbench for pwm_deadtime: vector table, directed multi-cycle sequences,
// and randomized stimulus against a side-ownership reference model.
// Fault scenarios are included when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic       go;
    logic [7:0] dead_cnt;
    logic       relatch;
    logic       out_hi;
    logic       out_lo;
    logic       dead_active;
    logic [2:0] dbg_state;
`ifdef PWM_DEADTIME_FAULT_EN
    logic       fault;
    logic       fault_latched;
`endif

    pwm_deadtime #(.DEAD_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .go           (go),
        .dead_cnt     (dead_cnt),
        .relatch      (relatch),
`ifdef PWM_DEADTIME_FAULT_EN
        .fault        (fault),
        .fault_latched(fault_latched),
`endif
        .out_hi       (out_hi),
        .out_lo       (out_lo),
        .dead_active  (dead_active),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Expected lengths of consecutive both-low gaps (completed when a side turns on).
    logic [15:0] exp_q[$];
    int          gap_len = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which side owns the bridge (0 none, 1 high, 2 low), the side being
    // waited for, the side most recently released, and dead cycles still owed.
    int   m_on, m_target, m_from, m_left, m_dead_l;
    logic m_run, m_flt, m_pwm_r;

    task automatic model_reset();
        m_on = 0; m_target = 0; m_from = 0; m_left = 0; m_dead_l = 0;
        m_run = 1'b0; m_flt = 1'b0; m_pwm_r = 1'b0;
    endtask

    task automatic model_step(input logic g, input logic p, input logic [7:0] dc,
                              input logic rl, input logic f);
        int old_dl;
        int want;
        old_dl = m_dead_l;
        want   = m_pwm_r ? 1 : 2;
        if (!g) begin
            m_run = 1'b0; m_on = 0; m_flt = 1'b0;
        end else if (m_flt) begin
            m_on = 0;
        end else if (m_run && f) begin
            m_flt = 1'b1; m_on = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_dead_l = int'(dc); m_left = int'(dc);
            m_target = want; m_from = 3 - want; m_on = 0;
        end else begin
            if (rl) m_dead_l = int'(dc);
            if (m_on != 0) begin
                if (want != m_on) begin
                    m_from = m_on; m_on = 0; m_target = want; m_left = old_dl;
                end
            end else if (want == m_from) begin
                m_on = m_from;
            end else if (m_left == 0) begin
                m_on = m_target;
            end else begin
                m_left = m_left - 1;
            end
        end
        m_pwm_r = p;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic g, input logic p, input logic [7:0] dc,
                         input logic rl, input logic f);
        go = g; pwm_in = p; dead_cnt = dc; relatch = rl;
`ifdef PWM_DEADTIME_FAULT_EN
        fault = f;
`endif
        @(posedge clk);
        model_step(g, p, dc, rl, f);
        #1;
        check_bit("model_out_hi", out_hi, m_on == 1);
        check_bit("model_out_lo", out_lo, m_on == 2);
        check_bit("model_dead_active", dead_active, m_run && !m_flt && (m_on == 0));
        check_bit("no_overlap", out_hi & out_lo, 1'b0);
`ifdef PWM_DEADTIME_FAULT_EN
        check_bit("model_fault_latched", fault_latched, m_flt);
`endif
        if (!out_hi && !out_lo) begin
            gap_len++;
        end else begin
            if (gap_len > 0 && exp_q.size() > 0) begin
                check_int("dead_gap_len", gap_len, int'(exp_q.pop_front()));
            end
            gap_len = 0;
        end
    endtask

    task automatic gaps_done(input string name);
        check_int(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       go;
        logic       pwm;
        logic [7:0] dc;
        logic       rl;
        logic       hi;
        logic       lo;
        logic       dead;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic       p;
        logic       f;
        int         run_left;
        logic [7:0] dc;
        logic       seen_lo;
        logic       abort_hi[4];

        // Startup with dead_cnt=3 and pwm low, then a rising pwm edge.
        tbl[0]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        abort_hi = '{1'b1, 1'b0, 1'b0, 1'b1};

        // ---------------- reset ----------------
        rst = 1'b1; go = 1'b0; pwm_in = 1'b0; dead_cnt = 8'd0; relatch = 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
        fault = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_out_hi", out_hi, 1'b0);
        check_bit("reset_out_lo", out_lo, 1'b0);
        check_bit("reset_dead_active", dead_active, 1'b0);
        check_int("reset_state_idle", int'(dbg_state), 0);
        #3 rst = 1'b0;

        // go low with pwm toggling: nothing drives.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, i[0], 8'd3, 1'b0, 1'b0);
            check_bit("idle_toggle_hi", out_hi, 1'b0);
            check_bit("idle_toggle_lo", out_lo, 1'b0);
            check_bit("idle_toggle_dead", dead_active, 1'b0);
        end

        // ---------------- table ----------------
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].go, tbl[i].pwm, tbl[i].dc, tbl[i].rl, 1'b0);
            check_bit($sformatf("tbl%0d_hi", i), out_hi, tbl[i].hi);
            check_bit($sformatf("tbl%0d_lo", i), out_lo, tbl[i].lo);
            check_bit($sformatf("tbl%0d_dead", i), dead_active, tbl[i].dead);
        end

        // ---------------- dead_cnt=0 square wave, period 20 ----------------
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        gap_len = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'd1);
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, (i % 20) < 10, 8'd0, 1'b0, 1'b0);
        end
        gaps_done("square_gap_count");

        // ---------------- abort: short low pulse in HI_ON ----------------
        cycle(1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
        gap_len = 0;
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd2);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
        check_bit("abort_pre_hi", out_hi, 1'b1);
        seen_lo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i >= 2, 8'd5, 1'b0, 1'b0);
            check_bit($sformatf("abort_hi_%0d", i), out_hi, abort_hi[i]);
            seen_lo = seen_lo | out_lo;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
            seen_lo = seen_lo | out_lo;
        end
        check_bit("abort_lo_never", seen_lo, 1'b0);
        gaps_done("abort_gap_count");

        // ---------------- relatch mid-window ----------------
        cycle(1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        gap_len = 0;
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd8);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        check_bit("relatch_lo_on", out_lo, 1'b1);
        cycle(1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        check_bit("relatch_in_window", dead_active, 1'b1);
        cycle(1'b1, 1'b1, 8'd7, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        check_bit("relatch_hi_on", out_hi, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        check_bit("relatch_lo_again", out_lo, 1'b1);
        gaps_done("relatch_gap_count");
        cycle(1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        check_bit("go_low_hi", out_hi, 1'b0);
        check_bit("go_low_lo", out_lo, 1'b0);

        // ---------------- all-ones dead time ----------------
        gap_len = 0;
        exp_q.push_back(16'd256);
        for (int i = 0; i < 258; i++) cycle(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        check_bit("max_window_lo", out_lo, 1'b1);
        gaps_done("max_window_gap_count");
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // ---------------- asynchronous reset mid-window and while on ----------------
        cycle(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd4, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd4, 1'b0, 1'b0);
        check_bit("arst_pre_dead", dead_active, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("arst_window_dead", dead_active, 1'b0);
        check_bit("arst_window_hi", out_hi, 1'b0);
        go = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        cycle(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        check_bit("arst_pre_hi", out_hi, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("arst_on_hi", out_hi, 1'b0);
        check_bit("arst_on_lo", out_lo, 1'b0);
        go = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        gap_len = 0;

`ifdef PWM_DEADTIME_FAULT_EN
        // ---------------- fault latch ----------------
        cycle(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        check_bit("fault_pre_hi", out_hi, 1'b1);
        cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
        check_bit("fault_hi_off", out_hi, 1'b0);
        check_bit("fault_latched_set", fault_latched, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, i[0], 8'd1, i == 2, 1'b0);
            check_bit("fault_hold", fault_latched, 1'b1);
            check_bit("fault_hold_hi", out_hi, 1'b0);
            check_bit("fault_hold_lo", out_lo, 1'b0);
        end
        cycle(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        check_bit("fault_cleared", fault_latched, 1'b0);
        cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        check_bit("fault_restart_dead", dead_active, 1'b1);
        cycle(1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
`endif

        // ---------------- randomized ----------------
        p = 1'b0;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                p = ~p;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            if ($urandom_range(0, 3) == 0) dc = 8'($urandom_range(0, 15));
            else                           dc = 8'($urandom_range(0, 4));
            f = 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
            f = ($urandom_range(0, 149) == 0);
`endif
            cycle($urandom_range(0, 59) != 0, p, dc, $urandom_range(0, 19) == 0, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the PWM timer. Consumes the timer's single-ended pwm output and produces a complementary high-side/low-side drive pair.
- Inserts a programmable dead time so the two outputs are never asserted together.
- Sits between the timer and the gate-drive pins. Uses the same go/relatch control style as the timer.

Parameters:
DEAD_BITS, 8, width of dead-time count; dead window = dead_cnt + 1 clk cycles

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-high
pwm_in  in  1  PWM from timer; high = high-side on request
go  in  1  enable; low forces both outputs off
dead_cnt  in  DEAD_BITS  dead time setting; latched on go rise or relatch
relatch  in  1  one-cycle pulse; reload dead_cnt while running
out_hi  out  1  high-side drive, registered, active-high
out_lo  out  1  low-side drive, registered, active-high
dead_active  out  1  1 while in either dead window

Behaviour:
- Reset and clocking: one clock (clk). rst is asynchronous, active-high.
- Reset values: out_hi=0, out_lo=0, dead_active=0, state=IDLE, dead_l=0, cnt=0, pwm_r=0.
- Input sampling: pwm_in is registered into pwm_r every edge. All decisions use pwm_r.
- Outputs are registered and change on the same edge as the state transition:
  - IDLE: both outputs 0.
  - HI_ON: out_hi=1.
  - LO_ON: out_lo=1.
  - DEAD_TO_HI, DEAD_TO_LO: both outputs 0, dead_active=1.
- States: IDLE, DEAD_TO_HI, HI_ON, DEAD_TO_LO, LO_ON.
- IDLE:
  - go=1: latch dead_l<=dead_cnt and cnt<=dead_cnt.
  - Next state DEAD_TO_HI if pwm_r=1, else DEAD_TO_LO, so startup always gets a full dead window.
- LO_ON: pwm_r=1 -> DEAD_TO_HI, cnt<=dead_l.
- HI_ON: pwm_r=0 -> DEAD_TO_LO, cnt<=dead_l.
- DEAD_TO_x, each edge:
  - Abort: if pwm_r has flipped back to the side that was just switched off, return directly to that ON state. That side's counterpart never turned on, so this is safe.
  - Else if cnt==0 -> x_ON.
  - Else cnt<=cnt-1.
- Timing: both outputs are low for exactly dead_l+1 cycles. If pwm_r rises at edge k, out_lo falls at edge k+1 and out_hi rises at edge k+2+dead_l.
- Pulses: pwm pulses shorter than the dead window are swallowed. The outputs never glitch.
- Invariant: out_hi & out_lo == 0 on every cycle, including reset release and go toggling.
- go=0 in any state: next edge -> IDLE with both outputs 0. It takes precedence over relatch and over pwm_r.
- relatch=1 with go=1 and not IDLE: dead_l<=dead_cnt.
  - An in-progress dead window keeps its loaded cnt; the new value applies from the next window.
  - relatch does not stall the state machine.
- cnt is DEAD_BITS wide and never wraps: it is only decremented when nonzero.
- dead_cnt at all-ones gives a 2^DEAD_BITS-cycle window.
- rst asserted mid-window: outputs go to 0 immediately (asynchronously).

Optional Feature:
- Macro: PWM_DEADTIME_FAULT_EN.
- When defined:
  - Adds input fault (1 bit, synchronous) and output fault_latched (1 bit, reset 0).
  - fault=1 in any non-IDLE state -> next edge enters state FAULT: out_hi=0, out_lo=0, fault_latched=1.
  - FAULT is exited only by go=0 (-> IDLE, fault_latched<=0) or rst.
  - fault has priority over relatch and pwm_r; go=0 has priority over fault.
- When undefined: no fault ports and no FAULT state; behaviour is otherwise identical.

Test Plan:
- Reset, go=0, pwm_in toggling -> out_hi=out_lo=0 and dead_active=0 throughout.
- dead_cnt=3, go rises with pwm_in=0 -> both low 4 cycles, then out_lo=1. pwm_in rises at edge k -> out_lo=0 at k+1, out_hi=1 at k+5.
- dead_cnt=0, 50% square wave of period 20 -> exactly 1-cycle gaps at each edge. Assert out_hi&out_lo never 1.
- dead_cnt=5, HI_ON, pwm_in low for 2 cycles -> out_lo never asserts; out_hi returns at the next edge after the abort.
- Running with dead_cnt=2, pulse relatch with dead_cnt=7 mid-window -> current window 3 cycles, next window 8 cycles. go=0 -> both outputs 0 next edge.
- PWM_DEADTIME_FAULT_EN: fault pulse in HI_ON -> out_hi=0 next edge, fault_latched=1 held despite pwm activity; go=0 clears it; go=1 restarts with a dead window.
